// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a program into instruction memory, then runs the core and times it
module prog_loader #(
    parameter int D  = 12,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          ld_valid,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          imem_wr_en,
    output logic [D-1:0]  imem_wr_addr,
    output logic [W-1:0]  imem_wr_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          ack,
    output logic [D:0]    prog_len,
    output logic [CW-1:0] cycle_cnt,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FINISH} state_t;

    state_t        state;
    state_t        state_nx;
    logic [D-1:0]  ptr;
    logic          xfer;
    logic          at_end;

    assign xfer   = (state == LOAD) && ld_valid;
    assign at_end = (ptr == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            prog_len  <= '0;
            cycle_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        ptr       <= '0;
                        prog_len  <= '0;
                        cycle_cnt <= '0;
                        err       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        // The pointer parks at the top address instead of wrapping.
                        if (!at_end)
                            ptr <= ptr + D'(1);
                        prog_len <= prog_len + (D+1)'(1);
                        if (at_end && !ld_last)
                            err <= 1'b1;
                    end
                end
                RUN: begin
                    if (!core_done && cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        ld_ready   = 1'b0;
        imem_wr_en = 1'b0;
        core_reset = 1'b1;
        busy       = 1'b1;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req)
                    state_nx = LOAD;
            end
            LOAD: begin
                ld_ready   = 1'b1;
                imem_wr_en = ld_valid;
                if (ld_valid && (ld_last || at_end))
                    state_nx = START;
            end
            // One extra reset cycle so the core restarts at PC 0 after the final write.
            START: state_nx = RUN;
            RUN: begin
                core_reset = 1'b0;
                if (core_done)
                    state_nx = FINISH;
            end
            FINISH: begin
                ack      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem_wr_addr = ptr;
    assign imem_wr_dat  = ld_data;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized and directed bench for prog_loader against a session-level model
module tb_prog_loader;
    localparam int D    = 3;
    localparam int W    = 9;
    localparam int CW   = 4;
    localparam int DEPTH = 1 << D;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          ld_valid = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          imem_wr_en;
    logic [D-1:0]  imem_wr_addr;
    logic [W-1:0]  imem_wr_dat;
    logic          core_reset;
    logic          core_done = 1'b0;
    logic          busy;
    logic          ack;
    logic [D:0]    prog_len;
    logic [CW-1:0] cycle_cnt;
    logic          err;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] prog [0:15];
    logic [D+W-1:0] wq [$];

    prog_loader #(.D(D), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr), .imem_wr_dat(imem_wr_dat), .core_reset(core_reset),
        .core_done(core_done), .busy(busy), .ack(ack), .prog_len(prog_len),
        .cycle_cnt(cycle_cnt), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_wr_en && !reset)
            wq.push_back({imem_wr_addr, imem_wr_dat});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_core_reset"}, 32'(core_reset), 1);
        check({tag, "_ld_ready"}, 32'(ld_ready), 0);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_wr_en"}, 32'(imem_wr_en), 0);
    endtask

    // len words requested; the loader is expected to stop taking words at DEPTH
    task automatic run_session(input string tag, input int len, input int gapmax,
                               input int delay, input bit poke_req);
        int n;
        int gap;
        bit exp_err;
        n = (len > DEPTH) ? DEPTH : len;
        exp_err = (len > DEPTH);
        wq.delete();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check({tag, "_load_busy"}, 32'(busy), 1);
        check({tag, "_load_cleared"}, {err, 3'b0, cycle_cnt, 8'(prog_len)}, 0);
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, gapmax);
            for (int g = 0; g < gap; g++) begin
                ld_valid = 1'b0;
                #1 check({tag, "_gap_wr_en"}, 32'(imem_wr_en), 0);
                @(negedge clk);
            end
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == len - 1);
            #1 check({tag, "_ld_ready"}, 32'(ld_ready), 1);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check({tag, "_start_core_reset"}, 32'(core_reset), 1);
        check({tag, "_start_ld_ready"}, 32'(ld_ready), 0);
        check({tag, "_prog_len"}, 32'(prog_len), 32'(n));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_nwrites"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++)
            check({tag, "_write"}, 32'(wq[i]), 32'({D'(i), prog[i]}));
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            check({tag, "_run_core_reset"}, 32'(core_reset), 0);
            check({tag, "_run_busy"}, 32'(busy), 1);
            core_done = (k == delay);
            req = poke_req && (k == 1);
        end
        @(negedge clk);
        core_done = 1'b0;
        req = 1'b0;
        check({tag, "_ack"}, 32'(ack), 1);
        check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'((delay > CMAX) ? CMAX : delay));
        @(negedge clk);
        check_idle({tag, "_after"});
        check({tag, "_hold"}, {err, 3'b0, cycle_cnt, 8'(prog_len)},
              {exp_err, 3'b0, CW'((delay > CMAX) ? CMAX : delay), 8'(n)});
        check({tag, "_nwrites_final"}, 32'(wq.size()), 32'(n));
        repeat (2) @(negedge clk);
        check({tag, "_no_restart"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_regs", {err, 3'b0, cycle_cnt, 8'(prog_len)}, 0);
        reset = 1'b0;

        prog[0] = 9'h1A3; prog[1] = 9'h044; prog[2] = 9'h1FF;
        run_session("basic", 3, 0, 7, 1'b0);
        run_session("backpressure", 3, 2, 3, 1'b0);

        for (int i = 0; i < DEPTH; i++) prog[i] = W'($urandom);
        run_session("overflow", 12, 1, 2, 1'b0);

        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = W'($urandom);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        check("midreset_regs", {err, 3'b0, cycle_cnt, 8'(prog_len)}, 0);
        reset = 1'b0;
        prog[0] = W'($urandom);
        run_session("after_reset", 1, 0, 1, 1'b0);

        run_session("saturate", 4, 1, 20, 1'b1);

        for (int s = 0; s < 8; s++) begin
            int len;
            len = $urandom_range(1, DEPTH + 3);
            for (int i = 0; i < DEPTH; i++) prog[i] = W'($urandom);
            run_session("random", len, 2, $urandom_range(0, 22), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
